// File: rtl/key_event_controller.sv
// Scan-code sequencer that turns set-2 byte streams into key events.
// Decoded events go into a show-ahead FIFO; parity errors and idle timeouts abort a partial sequence.
module key_event_controller #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_byte,
    input  logic                         rx_parity_err,
    input  logic                         evt_ready,
    input  logic                         ovf_clr,
    output logic                         evt_valid,
    output logic [9:0]                   evt_data,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic                         bat_ok,
    output logic                         bat_fail,
    output logic                         rx_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        SKIP_PAUSE
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    skip_cnt, skip_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit;

    logic          push;
    logic [9:0]    push_data;
    logic          bat_ok_nxt, bat_fail_nxt, rx_err_nxt;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          full, empty, pop, wr_en, drop;

    // Timeout only matters mid-sequence; a byte on the same cycle always wins.
    assign timeout_hit = (state != IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            skip_cnt <= '0;
            bat_ok   <= 1'b0;
            bat_fail <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            bat_ok   <= bat_ok_nxt;
            bat_fail <= bat_fail_nxt;
            rx_err   <= rx_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (rx_valid) begin
            tmo_cnt <= '0;
        end else if (state != IDLE && tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        skip_nxt     = skip_cnt;
        push         = 1'b0;
        push_data    = '0;
        bat_ok_nxt   = 1'b0;
        bat_fail_nxt = 1'b0;
        rx_err_nxt   = 1'b0;

        if (timeout_hit) begin
            state_nxt  = IDLE;
            skip_nxt   = '0;
            rx_err_nxt = 1'b1;
        end else if (rx_valid) begin
            if (rx_parity_err) begin
                state_nxt  = IDLE;
                skip_nxt   = '0;
                rx_err_nxt = 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        unique case (rx_byte)
                            8'hE0: state_nxt = GOT_E0;
                            8'hF0: state_nxt = GOT_F0;
                            8'hE1: begin
                                state_nxt = SKIP_PAUSE;
                                skip_nxt  = 3'd7;
                            end
                            8'hAA: bat_ok_nxt   = 1'b1;
                            8'hFC: bat_fail_nxt = 1'b1;
                            8'h00, 8'hFF: rx_err_nxt = 1'b1;
                            default: begin
                                push      = 1'b1;
                                push_data = {2'b00, rx_byte};
                            end
                        endcase
                    end
                    GOT_E0: begin
                        if (rx_byte == 8'hF0) begin
                            state_nxt = GOT_E0F0;
                        end else if (rx_byte != 8'hE0) begin
                            push      = 1'b1;
                            push_data = {2'b01, rx_byte};
                            state_nxt = IDLE;
                        end
                    end
                    GOT_F0: begin
                        if (rx_byte != 8'hF0) begin
                            push      = 1'b1;
                            push_data = {2'b10, rx_byte};
                            state_nxt = IDLE;
                        end
                    end
                    GOT_E0F0: begin
                        state_nxt = IDLE;
                        if (rx_byte == 8'hE0 || rx_byte == 8'hF0) begin
                            rx_err_nxt = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_data = {2'b11, rx_byte};
                        end
                    end
                    SKIP_PAUSE: begin
                        // Pause is reported once, after its whole 8-byte burst.
                        skip_nxt = skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) begin
                            push      = 1'b1;
                            push_data = {2'b00, 8'hE1};
                            state_nxt = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    assign full  = (count == LVL_FULL);
    assign empty = (count == '0);
    assign pop   = !empty && evt_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    assign evt_valid  = !empty;
    assign evt_data   = empty ? '0 : mem[rd_ptr];
    assign fifo_level = count;

endmodule

// File: doc/key_event_controller.md
KEY_EVENT_CONTROLLER -- requirements
Module: key_event_controller

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, number of event entries; it SHALL be a power of two, minimum 2.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, the number of idle clk cycles after which a partial prefix sequence is abandoned.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 rx_valid  input  1  one-cycle strobe: a received scan-code byte is present.
REQ-006 rx_byte  input  8  received byte, already in normal bit order (bit 7 = MSB), valid when rx_valid=1.
REQ-007 rx_parity_err  input  1  parity/framing error flag for the byte, qualified by rx_valid.
REQ-008 evt_ready  input  1  consumer accepts the head event when high together with evt_valid.
REQ-009 ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 evt_valid  output  1  FIFO non-empty; head event presented.
REQ-011 evt_data  output  10  head event {release, extended, code[7:0]}, show-ahead.
REQ-012 fifo_level  output  clog2(FIFO_DEPTH)+1  current number of stored events.
REQ-013 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-014 bat_ok / bat_fail / rx_err  output  1 each  one-cycle pulses: 0xAA self-test pass, 0xFC self-test fail, and error/discard, respectively.

Function
REQ-015 The sequencer FSM SHALL have states IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_PAUSE; a byte is consumed only on a cycle with rx_valid=1.
REQ-016 In IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; 0xE1 -> SKIP_PAUSE with skip counter = 7; 0xAA -> bat_ok pulse, stay; 0xFC -> bat_fail pulse, stay; 0x00 or 0xFF -> rx_err pulse, stay; any other byte -> push {0,0,byte}.
REQ-017 In GOT_E0: 0xF0 -> GOT_E0F0; 0xE0 -> stay; any other byte -> push {0,1,byte}, go to IDLE.
REQ-018 In GOT_F0: 0xF0 -> stay; any other byte -> push {1,0,byte}, go to IDLE.
REQ-019 In GOT_E0F0: any byte other than 0xE0/0xF0 -> push {1,1,byte}, go to IDLE; 0xE0 or 0xF0 -> rx_err pulse, go to IDLE.
REQ-020 In SKIP_PAUSE: each byte decrements the skip counter; the byte that brings it from 1 to 0 SHALL push {0,0,0xE1} and go to IDLE; byte values are not checked.
REQ-021 rx_valid with rx_parity_err=1 SHALL, in any state, discard the byte, pulse rx_err, and force IDLE.
REQ-022 A timeout counter SHALL reset on every rx_valid and increment otherwise while not in IDLE; reaching TIMEOUT_CYCLES SHALL force IDLE and pulse rx_err; the counter SHALL saturate and SHALL NOT count in IDLE.
REQ-023 A push SHALL write the FIFO on the same edge at which the byte is sampled; evt_valid SHALL rise in the following cycle when the FIFO was empty (latency 1 cycle).
REQ-024 A pop SHALL occur on each edge where evt_valid and evt_ready are both 1; evt_data SHALL update to the next entry in the following cycle.
REQ-025 Push when full with no pop SHALL drop the event, leave FIFO contents unchanged, and set overflow.
REQ-026 Push and pop in the same cycle SHALL both succeed, including when full; fifo_level SHALL remain unchanged.
REQ-027 Pop when empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 ovf_clr SHALL clear overflow; if an overflow drop occurs in the same cycle, overflow SHALL remain 1 (set wins).
REQ-029 bat_ok, bat_fail and rx_err SHALL each be high for exactly one cycle per triggering event, asserted the cycle after the sampling edge.

Reset
REQ-030 While rst=0 at a rising edge: FSM -> IDLE, skip and timeout counters -> 0, FIFO emptied (evt_valid=0, fifo_level=0), overflow=0, bat_ok=bat_fail=rx_err=0; evt_data SHALL read 10'h000.
REQ-031 Reset mid-sequence (any prefix or SKIP_PAUSE) SHALL discard the partial sequence with no event and no rx_err pulse.

Verification
REQ-032 Bytes 0x1C, then 0xF0,0x1C, with evt_ready=1 -> events 10'h01C then 10'h21C, each evt_valid for 1 cycle.
REQ-033 Bytes 0xE0,0xF0,0x75 -> single event 10'h375; bytes 0xE1,0x14,0x77,0xE1,0xF0,0x14,0xF0,0x77 -> single event 10'h0E1.
REQ-034 evt_ready=0, FIFO_DEPTH=4, five bytes 0x15 -> fifo_level=4, overflow=1, head 10'h015; then simultaneous push and pop when full -> level stays 4.
REQ-035 Byte 0xF0 then no traffic for TIMEOUT_CYCLES -> rx_err pulse, IDLE; next byte 0x1C -> event 10'h01C (no release flag).
REQ-036 0xAA -> bat_ok pulse, no event; 0xE0 with rx_parity_err=1 -> rx_err pulse, state IDLE; rst=0 asserted after 0xE0 -> no event, all outputs at reset values.
